// File: rtl/bank_ram_subsystem.sv
// Banked scratchpad shared by NUM_SLOTS masters.
// A fixed-priority arbiter (slot 0 highest) feeds one in-order command FIFO.
// The FIFO head is issued every cycle to all masked banks, and read data
// returns to the originating slot RAM_LATENCY cycles after issue.
// Optional macro BANK_RAM_TRACE_EN adds simulation-only push/return trace prints.
module bank_ram_subsystem #(
  parameter int NUM_SLOTS   = 2,
  parameter int FIFO_DEPTH  = 4,
  parameter int NUM_BANKS   = 5,
  parameter int ADDR_WIDTH  = 9,
  parameter int DATA_WIDTH  = 32,
  parameter int RAM_LATENCY = 2
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [NUM_SLOTS-1:0]                      cmd_valid,
  output logic [NUM_SLOTS-1:0]                      cmd_ready,
  input  logic [NUM_SLOTS-1:0]                      cmd_rw,
  input  logic [NUM_SLOTS*NUM_BANKS-1:0]            cmd_mask,
  input  logic [NUM_SLOTS*ADDR_WIDTH-1:0]           cmd_addr,
  input  logic [NUM_SLOTS-1:0]                      wvalid,
  output logic [NUM_SLOTS-1:0]                      wready,
  input  logic [NUM_SLOTS*NUM_BANKS*DATA_WIDTH-1:0] wdata,
  output logic [NUM_SLOTS-1:0]                      rvalid,
  output logic [NUM_SLOTS*NUM_BANKS*DATA_WIDTH-1:0] rdata
);

  localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;
  localparam int LANE_W = NUM_BANKS * DATA_WIDTH;
  localparam int LAST   = RAM_LATENCY - 1;

  logic [NUM_SLOTS-1:0] eligible;
  logic [NUM_SLOTS-1:0] grant;
  logic [SLOT_W-1:0]    grant_id;
  logic                 push;
  logic                 pop;
  logic                 full;

  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     count;

  logic [SLOT_W-1:0]    f_slot  [FIFO_DEPTH];
  logic                 f_rw    [FIFO_DEPTH];
  logic [NUM_BANKS-1:0] f_mask  [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] f_addr [FIFO_DEPTH];
  logic [LANE_W-1:0]    f_wdata [FIFO_DEPTH];

  logic [SLOT_W-1:0]    head_slot;
  logic                 head_rw;
  logic [NUM_BANKS-1:0] head_mask;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [LANE_W-1:0]    head_wdata;

  logic [RAM_LATENCY-1:0] vld_p;
  logic [SLOT_W-1:0]      slot_p [RAM_LATENCY];
  logic [NUM_BANKS-1:0]   mask_p [RAM_LATENCY];
  logic [LANE_W-1:0]      bank_q;
  logic [LANE_W-1:0]      rd_last;

  // Arbitration: lowest-index eligible slot wins; nothing is granted while full or in reset
  always_comb begin
    eligible = cmd_valid & (~cmd_rw | wvalid);
    grant    = '0;
    grant_id = '0;
    if (!full && !rst) begin
      for (int s = NUM_SLOTS - 1; s >= 0; s--) begin
        if (eligible[s]) begin
          grant    = '0;
          grant[s] = 1'b1;
          grant_id = SLOT_W'(s);
        end
      end
    end
  end

  assign full      = (count == CNT_W'(FIFO_DEPTH));
  assign cmd_ready = grant;
  assign wready    = grant & cmd_rw;
  assign push      = |grant;
  assign pop       = !rst && (count != '0);

  assign head_slot  = f_slot[rd_ptr];
  assign head_rw    = f_rw[rd_ptr];
  assign head_mask  = f_mask[rd_ptr];
  assign head_addr  = f_addr[rd_ptr];
  assign head_wdata = f_wdata[rd_ptr];

  // FIFO control: wrap-around pointers plus occupancy counter
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // FIFO storage: capture the granted slot's command and write data
  always_ff @(posedge clk) begin
    if (push) begin
      f_slot[wr_ptr]  <= grant_id;
      f_rw[wr_ptr]    <= cmd_rw[grant_id];
      f_mask[wr_ptr]  <= cmd_mask[int'(grant_id)*NUM_BANKS +: NUM_BANKS];
      f_addr[wr_ptr]  <= cmd_addr[int'(grant_id)*ADDR_WIDTH +: ADDR_WIDTH];
      f_wdata[wr_ptr] <= wdata[int'(grant_id)*LANE_W +: LANE_W];
    end
  end

  // ---- issue stage: head op hits every masked bank (p0) ----
  for (genvar k = 0; k < NUM_BANKS; k++) begin : g_bank
    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] q_p0;
    // Single-port bank: write or read at the issued address
    always_ff @(posedge clk) begin
      if (pop && head_mask[k]) begin
        if (head_rw) mem[head_addr] <= head_wdata[k*DATA_WIDTH +: DATA_WIDTH];
        else         q_p0 <= mem[head_addr];
      end
    end
    assign bank_q[k*DATA_WIDTH +: DATA_WIDTH] = q_p0;
  end

  // Read tag valid pipeline, flushed by reset so in-flight reads are dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= pop && !head_rw;
      for (int i = 1; i < RAM_LATENCY; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  // Read tag payload travels alongside its valid bit
  always_ff @(posedge clk) begin
    slot_p[0] <= head_slot;
    mask_p[0] <= head_mask;
    for (int i = 1; i < RAM_LATENCY; i++) begin
      slot_p[i] <= slot_p[i-1];
      mask_p[i] <= mask_p[i-1];
    end
  end

  // ---- bank data delay stages p1..pN to reach the full RAM latency ----
  if (RAM_LATENCY == 1) begin : g_lat1
    assign rd_last = bank_q;
  end else begin : g_latn
    logic [LANE_W-1:0] dly_p [RAM_LATENCY-1];
    // Extra read-latency stages behind the bank output register
    always_ff @(posedge clk) begin
      dly_p[0] <= bank_q;
      for (int i = 1; i < RAM_LATENCY - 1; i++) dly_p[i] <= dly_p[i-1];
    end
    assign rd_last = dly_p[RAM_LATENCY-2];
  end

  // ---- return stage: strobe the owning slot, zero the unmasked lanes ----
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid <= '0;
      rdata  <= '0;
    end else begin
      rvalid <= '0;
      if (vld_p[LAST]) begin
        rvalid[slot_p[LAST]] <= 1'b1;
        for (int k = 0; k < NUM_BANKS; k++) begin
          rdata[(int'(slot_p[LAST])*NUM_BANKS + k)*DATA_WIDTH +: DATA_WIDTH] <=
            mask_p[LAST][k] ? rd_last[k*DATA_WIDTH +: DATA_WIDTH] : '0;
        end
      end
    end
  end

`ifdef BANK_RAM_TRACE_EN
  // Simulation trace of every accepted command and every read return
  always_ff @(posedge clk) begin
    if (push)
      $display("%0t push slot=%0d rw=%0b addr=%0h mask=%b wdata=%h", $time, grant_id,
               cmd_rw[grant_id], cmd_addr[int'(grant_id)*ADDR_WIDTH +: ADDR_WIDTH],
               cmd_mask[int'(grant_id)*NUM_BANKS +: NUM_BANKS],
               wdata[int'(grant_id)*LANE_W +: LANE_W]);
    for (int s = 0; s < NUM_SLOTS; s++)
      if (rvalid[s]) $display("%0t return slot=%0d rdata=%h", $time, s, rdata[s*LANE_W +: LANE_W]);
  end
`else
`endif

endmodule

// File: tb/tb_bank_ram_subsystem.sv
// Self-checking bench for bank_ram_subsystem: directed scenarios plus random
// traffic, checked every cycle against a queue-based behavioural model.
module tb_bank_ram_subsystem;
  localparam int NS = 2, FD = 4, NB = 5, AW = 9, DW = 32, L = 2;
  localparam int LW = NB * DW;

  logic                clk;
  logic                rst;
  logic [NS-1:0]       cmd_valid, cmd_ready, cmd_rw, wvalid, wready, rvalid;
  logic [NS*NB-1:0]    cmd_mask;
  logic [NS*AW-1:0]    cmd_addr;
  logic [NS*LW-1:0]    wdata, rdata;

  bank_ram_subsystem #(.NUM_SLOTS(NS), .FIFO_DEPTH(FD), .NUM_BANKS(NB), .ADDR_WIDTH(AW),
                       .DATA_WIDTH(DW), .RAM_LATENCY(L)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_mask(cmd_mask), .cmd_addr(cmd_addr), .wvalid(wvalid), .wready(wready),
    .wdata(wdata), .rvalid(rvalid), .rdata(rdata));

  typedef struct { int slot; bit rw; logic [NB-1:0] mask; logic [AW-1:0] addr; logic [LW-1:0] data; } op_t;
  typedef struct { int due; int slot; logic [LW-1:0] data; } ret_t;

  op_t         mq[$];
  ret_t        rq[$];
  logic [DW-1:0] mmem [NB][2**AW];
  logic [LW-1:0] hold [NS];
  int          edges = 0;
  int          samp_edge;
  int          compared, mismatched;
  logic [NS-1:0]    exp_ready, exp_wready, exp_rvalid, obs_ready, obs_wready, obs_rvalid;
  logic [NS*LW-1:0] exp_rdata, obs_rdata;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) edges <= edges + 1;

  function automatic logic [LW-1:0] fill(logic [DW-1:0] base, logic [DW-1:0] step);
    logic [LW-1:0] v;
    for (int k = 0; k < NB; k++) v[k*DW +: DW] = base + step * DW'(k);
    return v;
  endfunction

  function automatic logic [LW-1:0] rnd_lanes();
    logic [LW-1:0] v;
    for (int k = 0; k < NB; k++) v[k*DW +: DW] = $urandom;
    return v;
  endfunction

  task automatic idle();
    cmd_valid = '0; cmd_rw = '0; wvalid = '0; cmd_mask = '0; cmd_addr = '0; wdata = '0;
  endtask

  task automatic drive(int s, bit v, bit rw, bit wv, logic [NB-1:0] m, logic [AW-1:0] a, logic [LW-1:0] d);
    cmd_valid[s] = v; cmd_rw[s] = rw; wvalid[s] = wv;
    cmd_mask[s*NB +: NB] = m; cmd_addr[s*AW +: AW] = a; wdata[s*LW +: LW] = d;
  endtask

  // One clock: predict outputs from the model, sample the DUT, then advance the model across the edge.
  task automatic tick();
    int g; bit r; op_t op; ret_t rt;
    @(negedge clk);
    samp_edge = edges;
    r = rst;
    g = -1;
    if (!r && mq.size() < FD)
      for (int s = 0; s < NS; s++)
        if (g < 0 && cmd_valid[s] && (!cmd_rw[s] || wvalid[s])) g = s;
    exp_ready = '0; exp_wready = '0;
    if (g >= 0) begin exp_ready[g] = 1'b1; exp_wready[g] = cmd_rw[g]; end
    exp_rvalid = '0;
    if (rq.size() > 0 && rq[0].due == edges) begin
      rt = rq.pop_front();
      exp_rvalid[rt.slot] = 1'b1;
      hold[rt.slot] = rt.data;
    end
    for (int s = 0; s < NS; s++) exp_rdata[s*LW +: LW] = hold[s];
    obs_ready = cmd_ready; obs_wready = wready; obs_rvalid = rvalid; obs_rdata = rdata;
    if (g >= 0) begin
      op.slot = g; op.rw = cmd_rw[g]; op.mask = cmd_mask[g*NB +: NB];
      op.addr = cmd_addr[g*AW +: AW]; op.data = wdata[g*LW +: LW];
    end
    @(posedge clk); #1;
    if (r) begin
      mq.delete(); rq.delete();
      for (int s = 0; s < NS; s++) hold[s] = '0;
    end else begin
      if (mq.size() > 0) begin
        op_t h;
        h = mq.pop_front();
        if (h.rw) begin
          for (int k = 0; k < NB; k++) if (h.mask[k]) mmem[k][h.addr] = h.data[k*DW +: DW];
        end else begin
          rt.due = edges + L; rt.slot = h.slot;
          for (int k = 0; k < NB; k++) rt.data[k*DW +: DW] = h.mask[k] ? mmem[k][h.addr] : '0;
          rq.push_back(rt);
        end
      end
      if (g >= 0) mq.push_back(op);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; idle();
    for (int c = 0; c < 3; c++) begin
      tick();
      if (c > 0) begin
        compared++; if ({obs_ready, obs_wready, obs_rvalid} !== '0) begin mismatched++;
          $display("FAIL reset_handshake got %b/%b/%b want 0", obs_ready, obs_wready, obs_rvalid); end
        compared++; if (obs_rdata !== '0) begin mismatched++;
          $display("FAIL reset_rdata got %h want 0", obs_rdata); end
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_full_lane();
    int p0 = 0, p1 = 0;
    for (int c = 0; c < 9; c++) begin
      idle();
      case (c)
        0: drive(0, 1, 1, 1, 5'b11111, 9'd10, fill(32'hAAAA0000, 32'd1));
        1: drive(0, 1, 0, 0, 5'b11111, 9'd10, '0);
        default: ;
      endcase
      tick();
      p0 += int'(obs_rvalid[0]); p1 += int'(obs_rvalid[1]);
      compared++; if ({obs_ready, obs_wready} !== {exp_ready, exp_wready}) begin mismatched++;
        $display("FAIL full_lane_ready c%0d got %b/%b want %b/%b", c, obs_ready, obs_wready, exp_ready, exp_wready); end
      compared++; if (obs_rvalid !== exp_rvalid) begin mismatched++;
        $display("FAIL full_lane_rvalid c%0d got %b want %b", c, obs_rvalid, exp_rvalid); end
      compared++; if (obs_rdata !== exp_rdata) begin mismatched++;
        $display("FAIL full_lane_rdata c%0d got %h want %h", c, obs_rdata, exp_rdata); end
    end
    compared++; if (p0 != 1 || p1 != 0) begin mismatched++;
      $display("FAIL full_lane_pulses got %0d/%0d want 1/0", p0, p1); end
    compared++; if (obs_rdata[0 +: LW] !== fill(32'hAAAA0000, 32'd1)) begin mismatched++;
      $display("FAIL full_lane_data got %h want %h", obs_rdata[0 +: LW], fill(32'hAAAA0000, 32'd1)); end
  endtask

  task automatic test_partial_mask();
    int p0 = 0, p1 = 0;
    logic [LW-1:0] d;
    d = rnd_lanes(); d[0 +: DW] = 32'hCCCC0000;
    for (int c = 0; c < 9; c++) begin
      idle();
      case (c)
        0: drive(1, 1, 1, 1, 5'b00001, 9'd50, d);
        1: drive(1, 1, 0, 0, 5'b00001, 9'd50, '0);
        default: ;
      endcase
      tick();
      p0 += int'(obs_rvalid[0]); p1 += int'(obs_rvalid[1]);
      compared++; if ({obs_ready, obs_wready} !== {exp_ready, exp_wready}) begin mismatched++;
        $display("FAIL partial_ready c%0d got %b/%b want %b/%b", c, obs_ready, obs_wready, exp_ready, exp_wready); end
      compared++; if (obs_rvalid !== exp_rvalid) begin mismatched++;
        $display("FAIL partial_rvalid c%0d got %b want %b", c, obs_rvalid, exp_rvalid); end
      compared++; if (obs_rdata !== exp_rdata) begin mismatched++;
        $display("FAIL partial_rdata c%0d got %h want %h", c, obs_rdata, exp_rdata); end
    end
    compared++; if (p0 != 0 || p1 != 1) begin mismatched++;
      $display("FAIL partial_pulses got %0d/%0d want 0/1", p0, p1); end
    compared++; if (obs_rdata[LW +: LW] !== {128'h0, 32'hCCCC0000}) begin mismatched++;
      $display("FAIL partial_data got %h want %h", obs_rdata[LW +: LW], {128'h0, 32'hCCCC0000}); end
  endtask

  task automatic test_priority();
    logic [NS-1:0] want;
    for (int c = 0; c < 10; c++) begin
      idle();
      case (c)
        0: begin drive(0, 1, 1, 1, 5'b11111, 9'd100, fill(32'h11111111, 0));
                 drive(1, 1, 1, 1, 5'b11111, 9'd200, fill(32'h22222222, 0)); end
        1: drive(1, 1, 1, 1, 5'b11111, 9'd200, fill(32'h22222222, 0));
        2: begin drive(0, 1, 0, 0, 5'b11111, 9'd100, '0); drive(1, 1, 0, 0, 5'b11111, 9'd200, '0); end
        3: drive(1, 1, 0, 0, 5'b11111, 9'd200, '0);
        default: ;
      endcase
      tick();
      if (c < 4) begin
        want = (c == 0 || c == 2) ? 2'b01 : 2'b10;
        compared++; if (obs_ready !== want) begin mismatched++;
          $display("FAIL priority_grant c%0d got %b want %b", c, obs_ready, want); end
      end
      compared++; if ({obs_ready, obs_wready} !== {exp_ready, exp_wready}) begin mismatched++;
        $display("FAIL priority_ready c%0d got %b/%b want %b/%b", c, obs_ready, obs_wready, exp_ready, exp_wready); end
      compared++; if (obs_rvalid !== exp_rvalid) begin mismatched++;
        $display("FAIL priority_rvalid c%0d got %b want %b", c, obs_rvalid, exp_rvalid); end
      compared++; if (obs_rdata !== exp_rdata) begin mismatched++;
        $display("FAIL priority_rdata c%0d got %h want %h", c, obs_rdata, exp_rdata); end
    end
    compared++; if (obs_rdata !== {fill(32'h22222222, 0), fill(32'h11111111, 0)}) begin mismatched++;
      $display("FAIL priority_data got %h", obs_rdata); end
  endtask

  task automatic test_latency();
    int acc = 0, first = -1, pulses = 0;
    for (int c = 0; c < 9; c++) begin
      idle();
      if (c == 0) drive(0, 1, 0, 0, 5'b11111, 9'd10, '0);
      tick();
      if (c == 0) acc = samp_edge + 1;
      if (obs_rvalid[0]) begin pulses++; if (first < 0) first = samp_edge; end
      compared++; if (obs_rvalid !== exp_rvalid) begin mismatched++;
        $display("FAIL latency_rvalid c%0d got %b want %b", c, obs_rvalid, exp_rvalid); end
      compared++; if (obs_rdata !== exp_rdata) begin mismatched++;
        $display("FAIL latency_rdata c%0d got %h want %h", c, obs_rdata, exp_rdata); end
      if (first >= 0 && samp_edge == first + 1) begin
        compared++; if (obs_rvalid[0] !== 1'b0 || obs_rdata[0 +: LW] !== fill(32'hAAAA0000, 32'd1)) begin
          mismatched++; $display("FAIL latency_hold got %b/%h want 0/%h", obs_rvalid[0],
                                 obs_rdata[0 +: LW], fill(32'hAAAA0000, 32'd1)); end
      end
    end
    compared++; if (first != acc + 1 + L || pulses != 1) begin mismatched++;
      $display("FAIL latency_edge got %0d (pulses %0d) want %0d (pulses 1)", first, pulses, acc + 1 + L); end
  endtask

  task automatic test_back_to_back();
    int accepted = 0;
    logic [LW-1:0] d20, d21;
    d20 = rnd_lanes(); d21 = rnd_lanes();
    for (int c = 0; c < 11; c++) begin
      idle();
      case (c)
        0: drive(0, 1, 1, 1, 5'b11111, 9'd20, d20);
        1: drive(0, 1, 1, 1, 5'b11111, 9'd21, d21);
        2: drive(0, 1, 0, 0, 5'b11111, 9'd20, '0);
        3: drive(0, 1, 0, 0, 5'b11111, 9'd21, '0);
        4: drive(0, 1, 0, 0, 5'(($urandom % 31) + 1), 9'd10, '0);
        default: ;
      endcase
      tick();
      if (c < 5) accepted += int'(obs_ready[0]);
      compared++; if ({obs_ready, obs_wready} !== {exp_ready, exp_wready}) begin mismatched++;
        $display("FAIL b2b_ready c%0d got %b/%b want %b/%b", c, obs_ready, obs_wready, exp_ready, exp_wready); end
      compared++; if (obs_rvalid !== exp_rvalid) begin mismatched++;
        $display("FAIL b2b_rvalid c%0d got %b want %b", c, obs_rvalid, exp_rvalid); end
      compared++; if (obs_rdata !== exp_rdata) begin mismatched++;
        $display("FAIL b2b_rdata c%0d got %h want %h", c, obs_rdata, exp_rdata); end
    end
    compared++; if (accepted != 5) begin mismatched++;
      $display("FAIL b2b_accepted got %0d want 5", accepted); end
  endtask

  task automatic test_wvalid_block();
    logic [LW-1:0] d;
    d = rnd_lanes();
    for (int c = 0; c < 9; c++) begin
      idle();
      case (c)
        0: begin drive(0, 1, 1, 0, 5'b11111, 9'd30, d); drive(1, 1, 0, 0, 5'b11111, 9'd10, '0); end
        1: drive(0, 1, 1, 1, 5'b11111, 9'd30, d);
        2: drive(0, 1, 0, 0, 5'b11111, 9'd30, '0);
        default: ;
      endcase
      tick();
      if (c < 2) begin
        compared++; if ({obs_ready, obs_wready} !== ((c == 0) ? 4'b10_00 : 4'b01_01)) begin mismatched++;
          $display("FAIL wvalid_gate c%0d got %b/%b", c, obs_ready, obs_wready); end
      end
      compared++; if ({obs_ready, obs_wready} !== {exp_ready, exp_wready}) begin mismatched++;
        $display("FAIL wvalid_ready c%0d got %b/%b want %b/%b", c, obs_ready, obs_wready, exp_ready, exp_wready); end
      compared++; if (obs_rvalid !== exp_rvalid) begin mismatched++;
        $display("FAIL wvalid_rvalid c%0d got %b want %b", c, obs_rvalid, exp_rvalid); end
      compared++; if (obs_rdata !== exp_rdata) begin mismatched++;
        $display("FAIL wvalid_rdata c%0d got %h want %h", c, obs_rdata, exp_rdata); end
    end
    compared++; if (obs_rdata !== {fill(32'hAAAA0000, 32'd1), d}) begin mismatched++;
      $display("FAIL wvalid_data got %h", obs_rdata); end
  endtask

  task automatic test_reset_midflight();
    int pulses = 0;
    for (int c = 0; c < 9; c++) begin
      idle();
      rst = (c == 2);
      if (c == 0) drive(1, 1, 0, 0, 5'b11111, 9'd10, '0);
      tick();
      if (c >= 2) pulses += $countones(obs_rvalid);
      compared++; if ({obs_ready, obs_wready} !== {exp_ready, exp_wready}) begin mismatched++;
        $display("FAIL midrst_ready c%0d got %b/%b want %b/%b", c, obs_ready, obs_wready, exp_ready, exp_wready); end
      compared++; if (obs_rvalid !== exp_rvalid) begin mismatched++;
        $display("FAIL midrst_rvalid c%0d got %b want %b", c, obs_rvalid, exp_rvalid); end
      compared++; if (obs_rdata !== exp_rdata) begin mismatched++;
        $display("FAIL midrst_rdata c%0d got %h want %h", c, obs_rdata, exp_rdata); end
    end
    rst = 1'b0;
    compared++; if (pulses != 0 || obs_rdata !== '0) begin mismatched++;
      $display("FAIL midrst_drop got pulses %0d rdata %h want 0/0", pulses, obs_rdata); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 16 + 240 + 8; c++) begin
      idle();
      rst = 1'b0;
      if (c < 16) begin
        drive(c % NS, 1, 1, 1, 5'b11111, AW'(c), rnd_lanes());
      end else if (c < 256) begin
        rst = ($urandom % 60 == 0);
        for (int s = 0; s < NS; s++)
          drive(s, 1'($urandom), 1'($urandom), ($urandom % 4 != 0), 5'($urandom),
                AW'($urandom % 16), rnd_lanes());
      end
      tick();
      compared++; if ({obs_ready, obs_wready} !== {exp_ready, exp_wready}) begin mismatched++;
        $display("FAIL random_ready c%0d got %b/%b want %b/%b", c, obs_ready, obs_wready, exp_ready, exp_wready); end
      compared++; if (obs_rvalid !== exp_rvalid) begin mismatched++;
        $display("FAIL random_rvalid c%0d got %b want %b", c, obs_rvalid, exp_rvalid); end
      compared++; if (obs_rdata !== exp_rdata) begin mismatched++;
        $display("FAIL random_rdata c%0d got %h want %h", c, obs_rdata, exp_rdata); end
    end
    rst = 1'b0;
  endtask

  initial begin
    compared = 0; mismatched = 0;
    for (int s = 0; s < NS; s++) hold[s] = '0;
    idle(); rst = 1'b1;
    test_reset();
    test_full_lane();
    test_partial_mask();
    test_priority();
    test_latency();
    test_back_to_back();
    test_wvalid_block();
    test_reset_midflight();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
